rx_hp_addr_table: RTL and testbench



---
 rtl/rx_hp_pkg.sv | 23 ++
 rtl/rx_hp_page_slot.sv | 39 +++
 rtl/rx_hp_addr_table.sv | 149 ++++++++++++++
 tb/tb_rx_hp_addr_table.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/rx_hp_pkg.sv
// Shared TLP fmt/type codes, receiver FSM encoding and the byte-swap helper
// used when turning little-endian payload DWs into page addresses.
package rx_hp_pkg;

  localparam logic [6:0] MWR32   = 7'b10_00000;
  localparam logic [6:0] MWR64   = 7'b11_00000;
  localparam logic [6:0] MRD32   = 7'b00_00000;
  localparam logic [6:0] MRD64   = 7'b01_00000;
  localparam logic [6:0] IO_RD32 = 7'b00_00010;
  localparam logic [6:0] IO_WR32 = 7'b10_00010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_SKIP = 2'd3
  } state_e;

  function automatic logic [31:0] bswap32(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/rx_hp_page_slot.sv
// One huge-page slot: 64-bit base address register plus its ready flag.
// Address loads whole in one edge; an unlock in the same cycle as a free leaves the page ready.
module rx_hp_page_slot
  import rx_hp_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        addr_we,
  input  logic [63:0] addr_d,
  input  logic        unlock,
  input  logic        free,
  output logic [63:0] addr_o,
  output logic        status_o
);

  logic [63:0] addr_q;
  logic        status_q;
  logic        status_d;

  always_comb begin
    status_d = status_q;
    if (free)   status_d = 1'b0;
    if (unlock) status_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      status_q <= 1'b0;
    end else begin
      if (addr_we) addr_q <= addr_d;
      status_q <= status_d;
    end
  end

  assign addr_o   = addr_q;
  assign status_o = status_q;

endmodule

// File: rtl/rx_hp_addr_table.sv
// Snoops the TRN RX stream for MWr32/MWr64 hits on one BAR and commits page addresses and
// unlocks on the accepted final beat; stalled beats hold all state, discard aborts the TLP.
module rx_hp_addr_table
  import rx_hp_pkg::*;
#(
  parameter int NUM_PAGES      = 2,
  parameter int BAR_NUM        = 2,
  parameter int ADDR_DW_BASE   = 16,
  parameter int UNLOCK_DW_BASE = 24
) (
  input  logic                      trn_clk,
  input  logic                      reset,
  input  logic [63:0]               trn_rd,
  input  logic [7:0]                trn_rrem_n,
  input  logic                      trn_rsof_n,
  input  logic                      trn_reof_n,
  input  logic                      trn_rsrc_rdy_n,
  input  logic                      trn_rdst_rdy_n,
  input  logic                      trn_rsrc_dsc_n,
  input  logic [6:0]                trn_rbar_hit_n,
  output logic [64*NUM_PAGES-1:0]   huge_page_addr,
  output logic [NUM_PAGES-1:0]      huge_page_status,
  input  logic [NUM_PAGES-1:0]      huge_page_free
);

  localparam int PW = (NUM_PAGES > 1) ? $clog2(NUM_PAGES) : 1;

  state_e          state_q, state_d;
  logic            is64_q, is64_d;
  logic [9:0]      len_q, len_d;
  logic [31:0]     data0_q, data0_d;
  logic [PW-1:0]   page_q, page_d;
  logic            unl_q, unl_d;

  logic acc, sof, eof, dsc, tracked;
  assign acc     = ~trn_rsrc_rdy_n & ~trn_rdst_rdy_n;
  assign sof     = acc & ~trn_rsof_n;
  assign eof     = acc & ~trn_reof_n;
  assign dsc     = ~trn_rsrc_dsc_n;
  assign tracked = ((trn_rd[62:56] == MWR32) || (trn_rd[62:56] == MWR64)) &&
                   !trn_rbar_hit_n[BAR_NUM];

  logic        unused_bits;
  assign unused_bits = ^{trn_rrem_n, trn_rbar_hit_n};

  // Offsets wrap modulo 128, so indices below a base fall far outside every range check.
  logic [5:0] dw_idx;
  logic [6:0] addr_off, unl_off;
  logic       addr_hit, unl_hit, go_data;
  assign dw_idx   = is64_q ? trn_rd[7:2] : trn_rd[39:34];
  assign addr_off = {1'b0, dw_idx} - 7'(ADDR_DW_BASE);
  assign unl_off  = {1'b0, dw_idx} - 7'(UNLOCK_DW_BASE);
  assign addr_hit = (addr_off < 7'(2 * NUM_PAGES)) && !addr_off[0] && (len_q == 10'd2);
  assign unl_hit  = (unl_off < 7'(NUM_PAGES)) && (len_q == 10'd1);
  assign go_data  = addr_hit || (unl_hit && is64_q);

  logic [31:0] w_data0, w_data1;
  logic [63:0] commit_addr;
  assign w_data0     = is64_q ? trn_rd[63:32] : data0_q;
  assign w_data1     = is64_q ? trn_rd[31:0]  : trn_rd[63:32];
  assign commit_addr = {bswap32(w_data1), bswap32(w_data0)};

  always_ff @(posedge trn_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      is64_q  <= 1'b0;
      len_q   <= '0;
      data0_q <= '0;
      page_q  <= '0;
      unl_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      is64_q  <= is64_d;
      len_q   <= len_d;
      data0_q <= data0_d;
      page_q  <= page_d;
      unl_q   <= unl_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (dsc) begin
      state_d = ST_IDLE;
    end else if (acc) begin
      case (state_q)
        ST_IDLE: if (sof && trn_reof_n) state_d = tracked ? ST_HDR : ST_SKIP;
        ST_HDR:  begin
          if (eof)          state_d = ST_IDLE;
          else if (go_data) state_d = ST_DATA;
          else              state_d = ST_SKIP;
        end
        ST_DATA: state_d = eof ? ST_IDLE : ST_SKIP;
        ST_SKIP: if (eof) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    is64_d  = is64_q;
    len_d   = len_q;
    data0_d = data0_q;
    page_d  = page_q;
    unl_d   = unl_q;
    if (acc && !dsc) begin
      if (state_q == ST_IDLE && sof && tracked) begin
        is64_d = trn_rd[61];
        len_d  = trn_rd[41:32];
      end
      if (state_q == ST_HDR) begin
        if (!is64_q) data0_d = trn_rd[31:0];
        page_d = addr_hit ? addr_off[PW:1] : unl_off[PW-1:0];
        unl_d  = !addr_hit;
      end
    end
  end

  logic [NUM_PAGES-1:0] addr_we, unlock;
  logic                 hdr_unlock, data_commit;
  assign hdr_unlock  = acc && !dsc && (state_q == ST_HDR) && unl_hit && !is64_q;
  assign data_commit = eof && !dsc && (state_q == ST_DATA);

  always_comb begin
    addr_we = '0;
    unlock  = '0;
    for (int i = 0; i < NUM_PAGES; i++) begin
      if (hdr_unlock && (unl_off[PW-1:0] == PW'(i))) unlock[i] = 1'b1;
      if (data_commit && (page_q == PW'(i))) begin
        if (unl_q) unlock[i]  = 1'b1;
        else       addr_we[i] = 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_PAGES; g++) begin : g_slot
    rx_hp_page_slot u_slot (
      .clk      (trn_clk),
      .reset    (reset),
      .addr_we  (addr_we[g]),
      .addr_d   (commit_addr),
      .unlock   (unlock[g]),
      .free     (huge_page_free[g]),
      .addr_o   (huge_page_addr[64*g +: 64]),
      .status_o (huge_page_status[g])
    );
  end

endmodule

// File: tb/tb_rx_hp_addr_table.sv
// Randomized TLP stream against a page-table model built from TLP fields, plus directed cases.
module tb_rx_hp_addr_table;

  localparam int NP = 4;
  localparam logic [6:0] FT_MWR32 = 7'h40;
  localparam logic [6:0] FT_MWR64 = 7'h60;
  localparam logic [6:0] FT_MRD32 = 7'h00;
  localparam logic [6:0] FT_IOWR  = 7'h42;

  logic               trn_clk = 1'b0;
  logic               reset;
  logic [63:0]        trn_rd;
  logic [7:0]         trn_rrem_n;
  logic               trn_rsof_n, trn_reof_n, trn_rsrc_rdy_n, trn_rdst_rdy_n, trn_rsrc_dsc_n;
  logic [6:0]         trn_rbar_hit_n;
  logic [64*NP-1:0]   huge_page_addr;
  logic [NP-1:0]      huge_page_status;
  logic [NP-1:0]      huge_page_free;

  always #5 trn_clk = ~trn_clk;

  rx_hp_addr_table #(.NUM_PAGES(NP), .BAR_NUM(2), .ADDR_DW_BASE(16), .UNLOCK_DW_BASE(24)) dut (
    .trn_clk          (trn_clk),
    .reset            (reset),
    .trn_rd           (trn_rd),
    .trn_rrem_n       (trn_rrem_n),
    .trn_rsof_n       (trn_rsof_n),
    .trn_reof_n       (trn_reof_n),
    .trn_rsrc_rdy_n   (trn_rsrc_rdy_n),
    .trn_rdst_rdy_n   (trn_rdst_rdy_n),
    .trn_rsrc_dsc_n   (trn_rsrc_dsc_n),
    .trn_rbar_hit_n   (trn_rbar_hit_n),
    .huge_page_addr   (huge_page_addr),
    .huge_page_status (huge_page_status),
    .huge_page_free   (huge_page_free)
  );

  logic [63:0]   m_addr [NP];
  logic [NP-1:0] m_status;
  logic [31:0]   tq[$];
  logic [6:0]    bar_v;
  int            nb;
  int            n_checks = 0;
  int            n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] d);
    logic [31:0] r;
    r = {<<8{d}};
    return r;
  endfunction

  task automatic check_all(input string tag);
    @(negedge trn_clk);
    for (int i = 0; i < NP; i++)
      check($sformatf("%s addr%0d", tag, i), huge_page_addr[64*i +: 64], m_addr[i]);
    check({tag, " status"}, 64'(huge_page_status), 64'(m_status));
  endtask

  task automatic step();
    @(posedge trn_clk);
    #1;
  endtask

  task automatic idle();
    trn_rsrc_rdy_n = 1'b1;
    trn_rdst_rdy_n = 1'($urandom);
    trn_rsof_n     = 1'($urandom);
    trn_reof_n     = 1'($urandom);
    trn_rd         = {$urandom, $urandom};
    trn_rsrc_dsc_n = 1'b1;
    huge_page_free = '0;
  endtask

  // Drive beats [b_from, b_to) of the TLP in tq, with optional unaccepted junk cycles in between.
  task automatic send(input bit stalls, input int dsc_beat, input logic [NP-1:0] free_last,
                      input int b_from, input int b_to);
    for (int b = b_from; b < b_to; b++) begin
      if (stalls) begin
        repeat ($urandom_range(0, 2)) begin
          trn_rd     = {$urandom, $urandom};
          trn_rsof_n = 1'($urandom);
          trn_reof_n = 1'($urandom);
          if ($urandom_range(0, 1) == 1) begin
            trn_rsrc_rdy_n = 1'b1; trn_rdst_rdy_n = 1'($urandom);
          end else begin
            trn_rsrc_rdy_n = 1'b0; trn_rdst_rdy_n = 1'b1;
          end
          step();
        end
      end
      trn_rd         = {tq[2*b], (2*b+1 < tq.size()) ? tq[2*b+1] : 32'h0};
      trn_rsof_n     = (b != 0);
      trn_reof_n     = (b != nb - 1);
      trn_rsrc_rdy_n = 1'b0;
      trn_rdst_rdy_n = 1'b0;
      trn_rsrc_dsc_n = (b != dsc_beat);
      trn_rbar_hit_n = bar_v;
      huge_page_free = (b == nb - 1) ? free_last : '0;
      step();
      idle();
      if (b != nb - 1) check_all("mid");
    end
  endtask

  task automatic build(input logic [6:0] ft, input int dw, input int len,
                       input logic [31:0] d0, input logic [31:0] d1, input bit hit);
    tq.delete();
    tq.push_back({1'b0, ft, 14'h0, 10'(len)});
    tq.push_back($urandom);
    if (ft[5]) tq.push_back($urandom);
    tq.push_back({24'($urandom), 6'(dw), 2'b00});
    if (ft[6])
      for (int k = 0; k < len; k++)
        tq.push_back(k == 0 ? d0 : (k == 1 ? d1 : $urandom));
    nb    = (tq.size() + 1) / 2;
    bar_v = hit ? 7'h7B : 7'h7F;
  endtask

  // Page-table effect of one complete, undiscarded TLP.
  task automatic apply(input logic [6:0] ft, input int dw, input int len,
                       input logic [31:0] d0, input logic [31:0] d1, input bit hit);
    int ai, ui;
    ai = dw - 16;
    ui = dw - 24;
    if (!hit || !(ft == FT_MWR32 || ft == FT_MWR64)) return;
    if (ai >= 0 && ai < 2*NP && ai % 2 == 0 && len == 2) m_addr[ai/2] = {bswap(d1), bswap(d0)};
    if (ui >= 0 && ui < NP && len == 1) m_status[ui] = 1'b1;
  endtask

  task automatic do_tlp(input logic [6:0] ft, input int dw, input int len,
                        input logic [31:0] d0, input logic [31:0] d1, input bit hit,
                        input bit stalls, input int dsc_beat, input logic [NP-1:0] free_last,
                        input string tag);
    int db;
    build(ft, dw, len, d0, d1, hit);
    db = (dsc_beat >= nb) ? -1 : dsc_beat;
    send(stalls, db, free_last, 0, nb);
    m_status &= ~free_last;
    if (db < 0) apply(ft, dw, len, d0, d1, hit);
    check_all(tag);
  endtask

  task automatic pulse_free(input logic [NP-1:0] m);
    huge_page_free = m;
    step();
    idle();
    m_status &= ~m;
    check_all("free");
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    for (int i = 0; i < NP; i++) m_addr[i] = '0;
    m_status = '0;
  endtask

  initial begin
    int r, len, dsc_b;
    logic [6:0] ft;
    logic [NP-1:0] fm;

    trn_rrem_n     = 8'h00;
    trn_rbar_hit_n = 7'h7F;
    bar_v          = 7'h7F;
    idle();
    do_reset();
    check_all("reset");
    check("reset status", 64'(huge_page_status), 64'h0);

    // Address write to page 0 with the byte order from the example payload.
    do_tlp(FT_MWR32, 16, 2, 32'h78563412, 32'hF0DEBC9A, 1'b1, 1'b0, -1, '0, "mwr32_addr");
    check("page0 value", huge_page_addr[63:0], 64'h9ABCDEF012345678);
    check("page0 status", 64'(huge_page_status), 64'h0);

    do_tlp(FT_MWR64, 25, 1, 32'h1, 32'h0, 1'b1, 1'b0, -1, '0, "mwr64_unlock");
    check("unlock p1", 64'(huge_page_status), 64'h2);
    pulse_free(4'b0010);
    check("free p1", 64'(huge_page_status), 64'h0);

    do_tlp(FT_MWR32, 24, 1, 32'h0, 32'h0, 1'b1, 1'b0, -1, 4'b0001, "unlock_vs_free");
    check("unlock wins", 64'(huge_page_status[0]), 64'h1);

    // Wrong length on an address register, then a back-to-back good write.
    do_tlp(FT_MWR32, 18, 1, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0, -1, '0, "len_mismatch");
    do_tlp(FT_MWR32, 18, 2, 32'h11223344, 32'h55667788, 1'b1, 1'b0, -1, '0, "b2b");
    check("page1 value", huge_page_addr[127:64], 64'h8877665544332211);

    do_tlp(FT_MWR64, 16, 2, 32'hAAAAAAAA, 32'hBBBBBBBB, 1'b1, 1'b1, 2, '0, "discard");
    check("discard keeps p0", huge_page_addr[63:0], 64'h9ABCDEF012345678);
    do_tlp(FT_MWR64, 22, 2, 32'h04030201, 32'h08070605, 1'b1, 1'b0, -1, '0, "after_dsc");
    check("page3 value", huge_page_addr[255:192], 64'h0506070801020304);

    // Reset between beat 1 and beat 2 of an address write, then the stray tail beat.
    build(FT_MWR32, 20, 2, 32'hCAFEF00D, 32'h12121212, 1'b1);
    send(1'b1, -1, '0, 0, 2);
    do_reset();
    check_all("rst_mid");
    check("rst_mid status", 64'(huge_page_status), 64'h0);
    send(1'b1, -1, '0, 2, 3);
    check_all("stray");
    do_tlp(FT_MWR32, 20, 2, 32'hCAFEF00D, 32'h12121212, 1'b1, 1'b1, -1, '0, "post_rst");

    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 9);
      ft = (r == 0) ? FT_MRD32 : (r == 1) ? FT_IOWR : (r < 6) ? FT_MWR32 : FT_MWR64;
      len = $urandom_range(1, 3);
      dsc_b = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : -1;
      fm = ($urandom_range(0, 3) == 0) ? 4'($urandom) : '0;
      do_tlp(ft, $urandom_range(14, 29), len, $urandom, $urandom, $urandom_range(0, 7) != 0,
             1'($urandom), dsc_b, fm, "rand");
      if ($urandom_range(0, 5) == 0) pulse_free(4'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
